uart_rx_param: RTL and testbench

Parametrised UART receiver, next generation of the team's 16x-oversampled receiver. It supports a configurable data width, optional even/odd parity and one or two stop bits. Each bit is decided by a 3-sample majority vote. The receiver reports parity, framing, break and overrun conditions. Received words are delivered through a valid/ready handshake, so the block can feed a FIFO or a command parser without dropping bytes silently.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_vote.sv | 48 ++++
 rtl/uart_rx_param.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the oversampled UART receiver family.
// Holds parity modes, FSM encodings, sample-counter landmarks and the vote helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [3:0] SMP_EARLY  = 4'd6;
    localparam logic [3:0] SMP_MID    = 4'd7;
    localparam logic [3:0] SMP_CENTER = 4'd8;
    localparam logic [3:0] SMP_TOP    = 4'd15;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic break_det;
    } rx_flags_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Two-flop synchroniser for rxd plus the 2-of-3 majority voter around the bit center.
// The vote is combinational from the two held samples and the live synchronised line.
module uart_rx_vote
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clken,
    input  logic [3:0] smp_cnt,
    input  logic       rxd,
    output logic       rxd_sync,
    output logic       vote_bit,
    output logic       vote_valid
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic s6_q, s6_d;
    logic s7_q, s7_d;

    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        s6_d    = s6_q;
        s7_d    = s7_q;
        if (clken && smp_cnt == SMP_EARLY) s6_d = sync2_q;
        if (clken && smp_cnt == SMP_MID)   s7_d = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            s6_q    <= 1'b1;
            s7_q    <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            s6_q    <= s6_d;
            s7_q    <= s7_d;
        end
    end

    assign rxd_sync   = sync2_q;
    assign vote_bit   = maj3(s6_q, s7_q, sync2_q);
    assign vote_valid = clken && (smp_cnt == SMP_CENTER);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised 16x-oversampled UART receiver: frame FSM, shift register and a
// valid/ready output register (valid holds until rx_valid && rx_ready; overrun pulses on drop).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clken_16bps,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic       rxd_sync;
    logic       vote_bit;
    logic       vote_valid;

    logic [2:0]           state_q, state_d;
    logic [3:0]           smp_cnt_q, smp_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 zero_q, zero_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    rx_flags_t            flags_q, flags_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_done;
    logic                 par_exp;

    uart_rx_vote u_vote (
        .clk        (clk),
        .rst_n      (rst_n),
        .clken      (clken_16bps),
        .smp_cnt    (smp_cnt_q),
        .rxd        (rxd),
        .rxd_sync   (rxd_sync),
        .vote_bit   (vote_bit),
        .vote_valid (vote_valid)
    );

    assign par_exp = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);

    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        zero_d     = zero_q;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                smp_cnt_d = 4'd0;
                bit_cnt_d = 4'd0;
                // Start detection is not gated by clken so the edge is caught promptly.
                if (!rxd_sync) begin
                    state_d = ST_START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    zero_d  = 1'b1;
                end
            end
            ST_START: begin
                if (clken_16bps) begin
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (vote_valid && vote_bit) begin
                        state_d   = ST_IDLE;
                        smp_cnt_d = 4'd0;
                    end else if (smp_cnt_q == SMP_TOP) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 4'd0;
                    end
                end
            end
            ST_DATA: begin
                if (clken_16bps) begin
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (vote_valid) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_cnt_q == 4'(i)) shift_d[i] = vote_bit;
                        end
                        zero_d = zero_q & ~vote_bit;
                    end
                    if (smp_cnt_q == SMP_TOP) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_d = 4'd0;
                            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (clken_16bps) begin
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (vote_valid) begin
                        perr_d = vote_bit ^ par_exp;
                        zero_d = zero_q & ~vote_bit;
                    end
                    if (smp_cnt_q == SMP_TOP) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clken_16bps) begin
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (vote_valid) begin
                        if (!vote_bit) ferr_d = 1'b1;
                        // Only the first stop bit takes part in break detection.
                        if (bit_cnt_q == 4'd0) zero_d = zero_q & ~vote_bit;
                        if (bit_cnt_q == LAST_STOP) begin
                            frame_done = 1'b1;
                            state_d    = ST_IDLE;
                            smp_cnt_d  = 4'd0;
                            bit_cnt_d  = 4'd0;
                        end
                    end else if (smp_cnt_q == SMP_TOP) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                smp_cnt_d = 4'd0;
                bit_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        flags_d    = flags_q;
        overrun_d  = 1'b0;
        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d          = shift_q;
                rx_valid_d         = 1'b1;
                flags_d.parity_err = perr_d;
                flags_d.frame_err  = ferr_d;
                flags_d.break_det  = zero_d;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            smp_cnt_q  <= 4'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            flags_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            flags_q    <= flags_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = flags_q.parity_err;
    assign frame_err  = flags_q.frame_err;
    assign break_det  = flags_q.break_det;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param in 8N1, 7E1 and 8N2 configurations.
// One bench tick is four clk cycles with clken_16bps high on the last.
module tb_uart_rx_param;

    logic clk;
    logic rst_n;
    logic clken;

    logic       rxd_a, rxd_b, rxd_c;
    logic       ready_a, ready_b, ready_c;
    logic [7:0] rx_data_a;
    logic [6:0] rx_data_b;
    logic [7:0] rx_data_c;
    logic       rx_valid_a, rx_valid_b, rx_valid_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       brk_a, brk_b, brk_c;
    logic       ovr_a, ovr_b, ovr_c;

    int n_vec = 0;
    int n_err = 0;
    int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
    int ocnt_a = 0;
    logic [31:0] exp_q[$];

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clken_16bps(clken), .rxd(rxd_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(ready_a),
        .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a), .overrun(ovr_a)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clken_16bps(clken), .rxd(rxd_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(ready_b),
        .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b), .overrun(ovr_b)
    );

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .clken_16bps(clken), .rxd(rxd_c),
        .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(ready_c),
        .parity_err(perr_c), .frame_err(ferr_c), .break_det(brk_c), .overrun(ovr_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // monitor / scoreboard for the 8N1 instance
    always @(negedge clk) begin
        if (rx_valid_a) vcnt_a++;
        if (rx_valid_b) vcnt_b++;
        if (rx_valid_c) vcnt_c++;
        if (ovr_a) ocnt_a++;
        if (rx_valid_a && ready_a) begin
            if (exp_q.size() == 0) check("a_sb_size", 32'(exp_q.size()), 32'd1);
            else check("a_sb_word", 32'(rx_data_a), exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic tick();
        repeat (3) @(negedge clk);
        clken = 1'b1;
        @(negedge clk);
        clken = 1'b0;
    endtask

    task automatic set_line(input int which, input logic v);
        case (which)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic idle(input int n);
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        rxd_c = 1'b1;
        repeat (n) tick();
    endtask

    task automatic drive_bit(input int which, input logic v, input bit flip7, input int hold);
        for (int t = 0; t < 16; t++) begin
            if (t >= hold)              set_line(which, 1'b1);
            else if (flip7 && t == 7)   set_line(which, ~v);
            else                        set_line(which, v);
            tick();
        end
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int par_mode, input bit par_flip, input logic [1:0] stops,
                              input int nstop, input bit noise);
        logic p;
        p = 1'b0;
        drive_bit(which, 1'b0, 1'b0, 16);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(which, data[i], noise, 16);
            p = p ^ data[i];
        end
        if (par_mode != 0) begin
            if (par_mode == 2) p = ~p;
            if (par_flip)      p = ~p;
            drive_bit(which, p, 1'b0, 16);
        end
        for (int i = 0; i < nstop; i++) begin
            drive_bit(which, stops[i], 1'b0, (i == nstop - 1) ? 9 : 16);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        clken   = 1'b0;
        rxd_a   = 1'b1;
        rxd_b   = 1'b1;
        rxd_c   = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
        ready_c = 1'b1;
        repeat (4) @(negedge clk);

        check("rst_valid_a", 32'(rx_valid_a), 32'd0);
        check("rst_data_a",  32'(rx_data_a),  32'd0);
        check("rst_perr_a",  32'(perr_a),     32'd0);
        check("rst_ferr_a",  32'(ferr_a),     32'd0);
        check("rst_brk_a",   32'(brk_a),      32'd0);
        check("rst_ovr_a",   32'(ovr_a),      32'd0);
        check("rst_valid_b", 32'(rx_valid_b), 32'd0);
        check("rst_valid_c", 32'(rx_valid_c), 32'd0);

        rst_n = 1'b1;
        idle(4);

        // 8N1 0xA5
        vcnt_a = 0;
        exp_q.push_back(32'hA5);
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        idle(8);
        check("a5_data", 32'(rx_data_a), 32'hA5);
        check("a5_vcnt", 32'(vcnt_a),    32'd1);
        check("a5_perr", 32'(perr_a),    32'd0);
        check("a5_ferr", 32'(ferr_a),    32'd0);
        check("a5_brk",  32'(brk_a),     32'd0);

        // 7E1 0x35: good parity, then inverted parity
        vcnt_b = 0;
        send_frame(1, 9'h035, 7, 1, 1'b0, 2'b11, 1, 1'b0);
        idle(8);
        check("e1_ok_data", 32'(rx_data_b), 32'h35);
        check("e1_ok_perr", 32'(perr_b),    32'd0);
        send_frame(1, 9'h035, 7, 1, 1'b1, 2'b11, 1, 1'b0);
        idle(8);
        check("e1_bad_data", 32'(rx_data_b), 32'h35);
        check("e1_bad_perr", 32'(perr_b),    32'd1);
        check("e1_bad_ferr", 32'(ferr_b),    32'd0);
        check("e1_bad_brk",  32'(brk_b),     32'd0);
        check("e1_vcnt",     32'(vcnt_b),    32'd2);

        // 4-tick glitch on idle line, then 0x3C
        vcnt_a = 0;
        set_line(0, 1'b0);
        repeat (4) tick();
        idle(40);
        check("glitch_vcnt", 32'(vcnt_a), 32'd0);
        check("glitch_data", 32'(rx_data_a), 32'hA5);
        exp_q.push_back(32'h3C);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        idle(8);
        check("3c_data", 32'(rx_data_a), 32'h3C);
        check("3c_vcnt", 32'(vcnt_a),    32'd1);
        check("3c_ferr", 32'(ferr_a),    32'd0);

        // 8N2: second stop bit low, then a break frame
        vcnt_c = 0;
        send_frame(2, 9'h081, 8, 0, 1'b0, 2'b01, 2, 1'b0);
        idle(32);
        check("n2_data", 32'(rx_data_c), 32'h81);
        check("n2_ferr", 32'(ferr_c),    32'd1);
        check("n2_brk",  32'(brk_c),     32'd0);
        send_frame(2, 9'h000, 8, 0, 1'b0, 2'b10, 2, 1'b0);
        idle(32);
        check("brk_data", 32'(rx_data_c), 32'h00);
        check("brk_ferr", 32'(ferr_c),    32'd1);
        check("brk_brk",  32'(brk_c),     32'd1);
        check("n2_vcnt",  32'(vcnt_c),    32'd2);

        // overrun with rx_ready held low
        ready_a = 1'b0;
        ocnt_a  = 0;
        exp_q.push_back(32'h11);
        send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        idle(8);
        check("ovr_first_valid", 32'(rx_valid_a), 32'd1);
        check("ovr_first_data",  32'(rx_data_a),  32'h11);
        send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        idle(8);
        check("ovr_hold_data",  32'(rx_data_a),  32'h11);
        check("ovr_hold_valid", 32'(rx_valid_a), 32'd1);
        check("ovr_pulses",     32'(ocnt_a),     32'd1);
        @(posedge clk);
        #1 ready_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_release_valid", 32'(rx_valid_a), 32'd0);
        check("ovr_release_data",  32'(rx_data_a),  32'h11);
        idle(4);

        // single-tick noise at smp_cnt 7 of each data bit
        exp_q.push_back(32'h5A);
        send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1, 1'b1);
        idle(8);
        check("noise_data", 32'(rx_data_a), 32'h5A);
        check("noise_ferr", 32'(ferr_a),    32'd0);

        // reset in the middle of a frame
        drive_bit(0, 1'b0, 1'b0, 16);
        drive_bit(0, 1'b0, 1'b0, 16);
        drive_bit(0, 1'b0, 1'b0, 16);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data",  32'(rx_data_a),  32'h00);
        check("mid_rst_valid", 32'(rx_valid_a), 32'd0);
        check("mid_rst_data_c", 32'(rx_data_c), 32'h00);
        check("mid_rst_ferr_c", 32'(ferr_c),    32'd0);
        rxd_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        exp_q.push_back(32'h96);
        send_frame(0, 9'h096, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        idle(8);
        check("post_rst_data", 32'(rx_data_a), 32'h96);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
